instr_loader: RTL and testbench

Writes a program image into instruction memory at run time. It accepts a byte stream over a valid/ready handshake and packs each group of 4 bytes into a big-endian 32-bit word, so the first byte received lands at byte offset 0 (MSB). It issues word writes on the write port of the instruction memory. It holds the CPU in reset while loading and releases it once the final word has been written.

---
 rtl/loader_pkg.sv | 19 +
 rtl/instr_loader_if.sv | 29 ++
 rtl/instr_loader_byte_packer.sv | 47 ++++
 rtl/instr_loader.sv | 126 ++++++++++++
 tb/tb_instr_loader.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/loader_pkg.sv
// Shared types and helpers for the instruction-memory loader slice.
package loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned WORD_BYTES = 4;

    function automatic logic [31:0] clamp_length(input int unsigned num_addresses,
                                                 input logic [31:0] len);
        logic [31:0] cap;
        cap = 32'd1 << num_addresses;
        return (len > cap) ? cap : len;
    endfunction

endpackage

// File: rtl/instr_loader_if.sv
// Byte-stream request side and instruction-memory write side of the loader.
interface instr_loader_if #(
    parameter int NUM_ADDRESSES     = 10,
    parameter int PC_WIDTH          = 32,
    parameter int DATA_WIDTH        = 8,
    parameter int INSTRUCTION_WIDTH = 32
);
    logic                         start;
    logic [NUM_ADDRESSES:0]       length;
    logic [DATA_WIDTH-1:0]        byte_in;
    logic                         byte_valid;
    logic                         byte_ready;
    logic                         mem_we;
    logic [PC_WIDTH-1:0]          mem_addr;
    logic [INSTRUCTION_WIDTH-1:0] mem_wdata;
    logic                         cpu_hold;
    logic                         done;

    modport master (
        output start, length, byte_in, byte_valid,
        input  byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done
    );

    modport slave (
        input  start, length, byte_in, byte_valid,
        output byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done
    );

endinterface

// File: rtl/instr_loader_byte_packer.sv
// Big-endian byte-to-word shift register with a byte-in-word counter.
module byte_packer
    import loader_pkg::*;
#(
    parameter int DATA_WIDTH        = 8,
    parameter int INSTRUCTION_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         shift_en,
    input  logic [DATA_WIDTH-1:0]        byte_in,
    output logic                         word_full,
    output logic [INSTRUCTION_WIDTH-1:0] flush
);

    logic [INSTRUCTION_WIDTH-1:0] pack_q, pack_d, shifted;
    logic [1:0]                   cnt_q, cnt_d;

    always_comb begin
        shifted   = {pack_q[INSTRUCTION_WIDTH-DATA_WIDTH-1:0], byte_in};
        word_full = shift_en && (cnt_q == 2'(WORD_BYTES - 1));
        // Word including the byte arriving now, left-aligned so a short tail is zero-padded.
        flush     = shifted << (DATA_WIDTH * (WORD_BYTES - 1 - 32'(cnt_q)));

        pack_d = pack_q;
        cnt_d  = cnt_q;
        if (clear || word_full) begin
            pack_d = '0;
            cnt_d  = '0;
        end else if (shift_en) begin
            pack_d = shifted;
            cnt_d  = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pack_q <= '0;
            cnt_q  <= '0;
        end else begin
            pack_q <= pack_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/instr_loader.sv
// Loads a byte-stream program image into instruction memory as big-endian
// words while holding the CPU in reset.
module instr_loader
    import loader_pkg::*;
#(
    parameter int NUM_ADDRESSES     = 10,
    parameter int PC_WIDTH          = 32,
    parameter int DATA_WIDTH        = 8,
    parameter int INSTRUCTION_WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    instr_loader_if.slave  bus
);

    localparam int CW = NUM_ADDRESSES + 1;

    state_t                       state_q, state_d;
    logic [CW-1:0]                target_q, target_d;
    logic [CW-1:0]                count_q, count_d;
    logic [PC_WIDTH-1:0]          word_addr_q, word_addr_d;
    logic                         mem_we_q, mem_we_d;
    logic [PC_WIDTH-1:0]          mem_addr_q, mem_addr_d;
    logic [INSTRUCTION_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                         byte_ready_q, byte_ready_d;
    logic                         cpu_hold_q, cpu_hold_d;
    logic                         done_q, done_d;

    logic                         xfer, last_byte, word_full, pack_clear;
    logic [INSTRUCTION_WIDTH-1:0] flush;

    byte_packer #(
        .DATA_WIDTH        (DATA_WIDTH),
        .INSTRUCTION_WIDTH (INSTRUCTION_WIDTH)
    ) u_packer (
        .clk       (clk),
        .rst_n     (rst),
        .clear     (pack_clear),
        .shift_en  (xfer),
        .byte_in   (bus.byte_in),
        .word_full (word_full),
        .flush     (flush)
    );

    assign xfer      = (state_q == LOAD) && bus.byte_valid;
    assign last_byte = xfer && (CW'(count_q + 1'b1) == target_q);

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        count_d     = count_q;
        word_addr_d = word_addr_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        pack_clear  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    target_d    = CW'(clamp_length(NUM_ADDRESSES, 32'(bus.length)));
                    count_d     = '0;
                    word_addr_d = '0;
                    pack_clear  = 1'b1;
                    state_d     = (target_d == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (xfer) begin
                    count_d = count_q + 1'b1;
                    if (word_full || last_byte) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = word_addr_q;
                        mem_wdata_d = flush;
                        word_addr_d = word_addr_q + PC_WIDTH'(WORD_BYTES);
                    end
                    if (last_byte) begin
                        pack_clear = 1'b1;
                        state_d    = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Status outputs are registered from the next state so they align with it.
        byte_ready_d = (state_d == LOAD);
        cpu_hold_d   = (state_d != IDLE);
        done_d       = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            target_q     <= '0;
            count_q      <= '0;
            word_addr_q  <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            byte_ready_q <= 1'b0;
            cpu_hold_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            count_q      <= count_d;
            word_addr_q  <= word_addr_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            byte_ready_q <= byte_ready_d;
            cpu_hold_q   <= cpu_hold_d;
            done_q       <= done_d;
        end
    end

    assign bus.byte_ready = byte_ready_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.cpu_hold   = cpu_hold_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed and randomized bench for instr_loader against a byte-list memory model.
module tb_instr_loader;

    localparam int NA  = 10;
    localparam int PCW = 32;
    localparam int DW  = 8;
    localparam int IW  = 32;
    localparam int LW  = NA + 1;
    localparam int unsigned MEM_BYTES = 1 << NA;

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_loader_if #(
        .NUM_ADDRESSES (NA), .PC_WIDTH (PCW), .DATA_WIDTH (DW), .INSTRUCTION_WIDTH (IW)
    ) bus ();

    instr_loader #(
        .NUM_ADDRESSES (NA), .PC_WIDTH (PCW), .DATA_WIDTH (DW), .INSTRUCTION_WIDTH (IW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [PCW-1:0] wr_addr[$];
    logic [IW-1:0]  wr_data[$];
    int unsigned    consumed = 0;

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            wr_addr.push_back(bus.mem_addr);
            wr_data.push_back(bus.mem_wdata);
        end
        if (bus.byte_valid === 1'b1 && bus.byte_ready === 1'b1) consumed++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ":byte_ready"}, bus.byte_ready, 0);
        check({tag, ":mem_we"},     bus.mem_we, 0);
        check({tag, ":mem_addr"},   bus.mem_addr, 0);
        check({tag, ":mem_wdata"},  bus.mem_wdata, 0);
        check({tag, ":cpu_hold"},   bus.cpu_hold, 0);
        check({tag, ":done"},       bus.done, 0);
    endtask

    function automatic bq_t rand_bytes(input int unsigned n);
        bq_t q;
        for (int unsigned i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        consumed = 0;
    endtask

    task automatic start_load(input int unsigned len);
        bus.start  = 1'b1;
        bus.length = LW'(len);
        @(posedge clk); #1;
        bus.start  = 1'b0;
        bus.length = LW'($urandom);
    endtask

    task automatic send_bytes(input string tag, input bq_t data, input bit gaps);
        int unsigned i = 0;
        int unsigned guard = 0;
        while (i < data.size() && guard < 20000) begin
            bus.byte_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.byte_in    = bus.byte_valid ? data[i] : 8'($urandom);
            @(negedge clk);
            if (bus.byte_valid && bus.byte_ready) i++;
            @(posedge clk); #1;
            guard++;
        end
        bus.byte_valid = 1'b0;
        check({tag, ":all_sent"}, i, data.size());
    endtask

    task automatic wait_done(input string tag, input bit expect_we);
        int unsigned g = 0;
        bit seen = 0;
        while (!seen && g < 3000) begin
            @(negedge clk);
            g++;
            if (bus.done === 1'b1) seen = 1;
        end
        check({tag, ":done_seen"}, seen, 1);
        check({tag, ":done_latency"}, g, 1);
        if (seen) begin
            check({tag, ":hold_at_done"}, bus.cpu_hold, 1);
            check({tag, ":we_at_done"}, bus.mem_we, expect_we);
            check({tag, ":ready_at_done"}, bus.byte_ready, 0);
            @(negedge clk);
            check({tag, ":done_one_cycle"}, bus.done, 0);
            check({tag, ":hold_released"}, bus.cpu_hold, 0);
        end
        @(posedge clk); #1;
    endtask

    // Expected memory image: byte b of the stream lands in word b/4 at lane b%4 from the MSB.
    task automatic verify_load(input string tag, input bq_t data, input int unsigned len);
        int unsigned n  = (len > MEM_BYTES) ? MEM_BYTES : len;
        int unsigned nw = (n + 3) / 4;
        logic [31:0] w;
        check({tag, ":num_writes"}, wr_addr.size(), nw);
        check({tag, ":consumed"}, consumed, n);
        for (int unsigned k = 0; k < nw && k < wr_addr.size(); k++) begin
            w = '0;
            for (int unsigned b = 0; b < 4; b++)
                if (4 * k + b < n) w[31 - 8 * b -: 8] = data[4 * k + b];
            check($sformatf("%s:addr%0d", tag, k), wr_addr[k], 4 * k);
            check($sformatf("%s:data%0d", tag, k), wr_data[k], w);
        end
    endtask

    task automatic run_load(input string tag, input bq_t data, input int unsigned len, input bit gaps);
        clear_log();
        start_load(len);
        @(negedge clk);
        check({tag, ":ready_after_start"}, bus.byte_ready, 1);
        check({tag, ":hold_after_start"}, bus.cpu_hold, 1);
        @(posedge clk); #1;
        send_bytes(tag, data, gaps);
        wait_done(tag, 1);
        verify_load(tag, data, len);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t d, head, tail;

        rst = 1'b0;
        bus.start = 1'b0;
        bus.length = '0;
        bus.byte_in = '0;
        bus.byte_valid = 1'b0;
        #12;
        check_reset_values("reset");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        d = {};
        for (int unsigned i = 0; i < 8; i++) d.push_back(8'(i));
        run_load("seq8", d, 8, 0);
        check("seq8:word0", wr_data.size() > 0 ? wr_data[0] : 'x, 32'h0001_0203);
        check("seq8:word1", wr_data.size() > 1 ? wr_data[1] : 'x, 32'h0405_0607);

        d = {};
        for (int unsigned i = 0; i < 6; i++) d.push_back(8'(8'hA0 + i));
        run_load("partial6", d, 6, 0);
        check("partial6:word1", wr_data.size() > 1 ? wr_data[1] : 'x, 32'hA4A5_0000);

        d = rand_bytes(12);
        run_load("gaps12", d, 12, 1);

        // byte_valid held high in IDLE must not consume anything
        clear_log();
        bus.byte_in = 8'hEE;
        bus.byte_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        bus.byte_valid = 1'b0;
        check("idle_valid:consumed", consumed, 0);
        check("idle_valid:writes", wr_addr.size(), 0);
        check("idle_valid:ready", bus.byte_ready, 0);

        d = rand_bytes(8);
        head = {};
        tail = {};
        for (int unsigned i = 0; i < 8; i++) if (i < 2) head.push_back(d[i]); else tail.push_back(d[i]);
        clear_log();
        start_load(8);
        send_bytes("misuse_a", head, 0);
        bus.start = 1'b1;
        bus.length = LW'(4);
        @(posedge clk); #1;
        bus.start = 1'b0;
        send_bytes("misuse_b", tail, 1);
        wait_done("misuse", 1);
        verify_load("misuse", d, 8);

        d = rand_bytes(8);
        clear_log();
        start_load(8);
        head = {};
        for (int unsigned i = 0; i < 7; i++) head.push_back(d[i]);
        send_bytes("rstmid", head, 0);
        rst = 1'b0;
        #1;
        check_reset_values("rstmid");
        @(posedge clk); #1;
        rst = 1'b1;
        bus.byte_in = 8'h55;
        bus.byte_valid = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        bus.byte_valid = 1'b0;
        check("rstmid:writes", wr_addr.size(), 1);
        check("rstmid:word0", wr_data.size() > 0 ? wr_data[0] : 'x, {d[0], d[1], d[2], d[3]});
        check("rstmid:no_consume_after", consumed, 7);

        d = rand_bytes(4);
        run_load("after_rst", d, 4, 0);

        d = rand_bytes(MEM_BYTES);
        run_load("clamp", d, 2000, 0);
        check("clamp:last_addr", wr_addr.size() > 0 ? wr_addr[wr_addr.size() - 1] : 'x, 32'h3FC);

        clear_log();
        start_load(0);
        @(negedge clk);
        check("zero:done", bus.done, 1);
        check("zero:we", bus.mem_we, 0);
        check("zero:ready", bus.byte_ready, 0);
        @(negedge clk);
        check("zero:done_low", bus.done, 0);
        check("zero:hold_low", bus.cpu_hold, 0);
        repeat (3) @(posedge clk);
        #1;
        check("zero:writes", wr_addr.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
